// File: rtl/ksa_pipe_param.sv
`timescale 1ns/1ps
// ksa_pipe_param
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
//
// Parameters
//   N          operand width (>= 2, any value)
//   REG_EVERY  a pipeline register follows every REG_EVERY-th prefix level
//              (1..LEVELS). Latency = 1 + (LEVELS-1)/REG_EVERY cycles,
//              where LEVELS = clog2(N).
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous clear of every in-flight valid bit
//   in_valid/in_ready input beat handshake (a, b, cin, sub)
//   sub               0: a + b + cin, 1: a - b - cin
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   cout              carry out of bit N-1 (in subtract mode 1 = no borrow)
//   ovf               signed overflow, carry into MSB xor carry out of MSB
//
// Handshake: a beat moves on either side only when valid and ready are both
// high in the same cycle. The whole pipe shares one enable, so a stalled
// result freezes every stage (no bubble collapse); in_ready = ~stall.
// flush wins over stall and input: all valid bits clear, data is kept.

module ksa_pipe_param #(
    parameter int N         = 16,
    parameter int REG_EVERY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int LEVELS = $clog2(N);

    logic stall;
    logic en;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // Operand conditioning: subtraction is a + ~b + 1, with the borrow-in
    // folded into the inverted carry-in.
    logic [N-1:0] b_eff;
    logic [N-1:0] p0;
    logic [N-1:0] g_raw;
    logic [N-1:0] g0;
    logic         cin_eff;

    assign b_eff   = b ^ {N{sub}};
    assign cin_eff = cin ^ sub;
    assign p0      = a ^ b_eff;
    assign g_raw   = a & b_eff;
    // Folding cin into bit 0's generate makes G[i] the carry into bit i+1.
    assign g0      = {g_raw[N-1:1], g_raw[0] | (p0[0] & cin_eff)};

    // Each level exposes go/pro/co/vo (group generate, raw propagate,
    // carry-in, valid) and, below the last level, g_p.po (group propagate).
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);

        logic [N-1:0] gi;
        logic [N-1:0] pi;
        logic [N-1:0] pri;
        logic         ci;
        logic         vi;
        logic [N-1:0] gn;
        logic [N-1:0] go;
        logic [N-1:0] pro;
        logic         co;
        logic         vo;

        if (k == 1) begin : g_src
            assign gi  = g0;
            assign pi  = p0;
            assign pri = p0;
            assign ci  = cin_eff;
            assign vi  = in_valid;
        end else begin : g_src
            assign gi  = g_lvl[k-1].go;
            assign pi  = g_lvl[k-1].g_p.po;
            assign pri = g_lvl[k-1].pro;
            assign ci  = g_lvl[k-1].co;
            assign vi  = g_lvl[k-1].vo;
        end

        // Bits below the span pass through unchanged.
        always_comb begin
            gn = gi;
            for (int i = D; i < N; i++) begin
                gn[i] = gi[i] | (pi[i] & gi[i-D]);
            end
        end

        if (k < LEVELS) begin : g_p
            logic [N-1:0] pn;
            logic [N-1:0] po;

            always_comb begin
                pn = pi;
                for (int i = D; i < N; i++) begin
                    pn[i] = pi[i] & pi[i-D];
                end
            end

            if ((k % REG_EVERY) == 0) begin : g_reg
                logic [N-1:0] gq;
                logic [N-1:0] pq;
                logic [N-1:0] prq;
                logic         cq;
                logic         vq;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vq  <= 1'b0;
                        gq  <= '0;
                        pq  <= '0;
                        prq <= '0;
                        cq  <= 1'b0;
                    end else if (flush) begin
                        vq <= 1'b0;
                    end else if (en) begin
                        vq  <= vi;
                        gq  <= gn;
                        pq  <= pn;
                        prq <= pri;
                        cq  <= ci;
                    end
                end

                assign po  = pq;
                assign go  = gq;
                assign pro = prq;
                assign co  = cq;
                assign vo  = vq;
            end else begin : g_comb
                assign po  = pn;
                assign go  = gn;
                assign pro = pri;
                assign co  = ci;
                assign vo  = vi;
            end
        end else begin : g_last
            assign go  = gn;
            assign pro = pri;
            assign co  = ci;
            assign vo  = vi;
        end
    end

    // c[0] = carry-in, c[i+1] = G[i].
    logic [N:0]   c_full;
    logic [N-1:0] sum_n;
    logic         cout_n;
    logic         ovf_n;
    logic         v_n;

    assign c_full = {g_lvl[LEVELS].go, g_lvl[LEVELS].co};
    assign sum_n  = g_lvl[LEVELS].pro ^ c_full[N-1:0];
    assign cout_n = c_full[N];
    assign ovf_n  = c_full[N] ^ c_full[N-1];
    assign v_n    = g_lvl[LEVELS].vo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= v_n;
            sum       <= sum_n;
            cout      <= cout_n;
            ovf       <= ovf_n;
        end
    end

endmodule

// File: tb/tb_ksa_pipe_param.sv
`timescale 1ns/1ps
// Bench for ksa_pipe_param. Four instances share the stimulus:
//   d0: N=16 REG_EVERY=1 (LAT 4)   d1: N=16 REG_EVERY=2 (LAT 2)
//   d2: N=16 REG_EVERY=4 (LAT 1)   d3: N=12 REG_EVERY=2 (LAT 2)
// Each instance has its own expected queue filled from an arithmetic model
// when it accepts a beat and drained when it hands a result over.

module tb_ksa_pipe_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_valid;
    logic out_ready;
    logic cin;
    logic sub;
    logic [15:0] a;
    logic [15:0] b;

    always #5 clk = ~clk;

    logic [15:0] sm  [4];
    logic        co  [4];
    logic        ov  [4];
    logic        ovl [4];
    logic        ir  [4];

    for (genvar j = 0; j < 4; j++) begin : g_dut
        localparam int NW = (j == 3) ? 12 : 16;
        localparam int RE = (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 4 : 2;
        logic [NW-1:0] s;

        ksa_pipe_param #(.N(NW), .REG_EVERY(RE)) dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (ir[j]),
            .a        (a[NW-1:0]),
            .b        (b[NW-1:0]),
            .cin      (cin),
            .sub      (sub),
            .out_valid(ovl[j]),
            .out_ready(out_ready),
            .sum      (s),
            .cout     (co[j]),
            .ovf      (ov[j])
        );

        assign sm[j] = 16'(s);
    end

    int lat_of [4] = '{4, 2, 1, 2};
    int nw_of  [4] = '{16, 16, 16, 12};

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q [4][$];
    int          t_q   [4][$];
    int          n_out [4];
    logic [17:0] held  [4];
    bit          held_v[4];
    bit          acc   [4];
    bit          check_lat;
    int          cyc;
    int          n_checks;
    int          n_pass;

    task automatic chk_eq(input string what, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", what, got, want);
    endtask

    // Reference: plain modular arithmetic on n-bit operands.
    function automatic logic [17:0] model(input int n, input logic [15:0] a_, input logic [15:0] b_,
                                          input logic ci, input logic sb);
        logic [16:0] mask;
        logic [16:0] am;
        logic [16:0] bm;
        logic [16:0] full;
        logic [15:0] s;
        logic        c;
        logic        o;
        mask = (17'd1 << n) - 17'd1;
        am   = {1'b0, a_} & mask;
        bm   = sb ? (~{1'b0, b_} & mask) : ({1'b0, b_} & mask);
        full = am + bm + {16'd0, ci ^ sb};
        s    = full[15:0] & mask[15:0];
        c    = full[n];
        o    = (am[n-1] == bm[n-1]) && (s[n-1] != am[n-1]);
        return {s, c, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [15:0] aa, input logic [15:0] bb,
                         input bit c, input bit s);
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = c;
        sub      = s;
    endtask

    // One clock: sample handshakes just before the edge, update the
    // scoreboard, then return at the following falling edge.
    task automatic tick();
        logic [17:0] got;
        logic [17:0] e;
        int          t;
        #1;
        for (int j = 0; j < 4; j++) begin
            acc[j] = in_valid && ir[j] && !flush && !rst;
            got    = {sm[j], co[j], ov[j]};
            if (!rst && ovl[j] && out_ready) begin
                chk_eq($sformatf("d%0d result pending", j), 32'(exp_q[j].size() > 0), 32'd1);
                if (exp_q[j].size() > 0) begin
                    e = exp_q[j].pop_front();
                    t = t_q[j].pop_front();
                    chk_eq($sformatf("d%0d result", j), 32'(got), 32'(e));
                    if (check_lat) chk_eq($sformatf("d%0d latency", j), 32'(cyc - t), 32'(lat_of[j]));
                end
                n_out[j]++;
                held_v[j] = 1'b0;
            end else if (!rst && ovl[j] && !out_ready) begin
                if (held_v[j]) chk_eq($sformatf("d%0d hold stable", j), 32'(got), 32'(held[j]));
                held[j]   = got;
                held_v[j] = 1'b1;
            end else begin
                held_v[j] = 1'b0;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (flush || rst) begin
                exp_q[j].delete();
                t_q[j].delete();
            end else if (acc[j]) begin
                exp_q[j].push_back(model(nw_of[j], a, b, cin, sub));
                t_q[j].push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_out(input string what, input int want_extra);
        int k = 0;
        while (!ovl[0] && k < 12) begin
            tick();
            k++;
        end
        chk_eq(what, 32'(k), 32'(want_extra));
    endtask

    task automatic check_drained(input string what);
        for (int j = 0; j < 4; j++)
            chk_eq($sformatf("d%0d %s drained", j, what), 32'(exp_q[j].size()), 32'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int i;
        int guard;
        bit bp [4];
        logic [11:0] corner [4];

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[9] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        bp     = '{1'b1, 1'b0, 1'b0, 1'b1};
        corner = '{12'h000, 12'hFFF, 12'h7FF, 12'h800};

        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        check_lat = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_out[j]  = 0;
            held_v[j] = 1'b0;
        end

        // ---- reset state ----
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk_eq("reset out_valid", 32'(ovl[0]), 32'd0);
        chk_eq("reset sum", 32'(sm[0]), 32'd0);
        chk_eq("reset cout", 32'(co[0]), 32'd0);
        chk_eq("reset ovf", 32'(ov[0]), 32'd0);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) chk_eq($sformatf("d%0d in_ready after reset", j), 32'(ir[j]), 32'd1);

        // ---- table vectors, one beat at a time on d0 ----
        for (int v = 0; v < 10; v++) begin
            drive(1'b1, tbl[v].a, tbl[v].b, tbl[v].cin, tbl[v].sub);
            tick();
            chk_eq($sformatf("tbl%0d accepted", v), 32'(acc[0]), 32'd1);
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            wait_out($sformatf("tbl%0d latency", v), lat_of[0] - 1);
            chk_eq($sformatf("tbl%0d sum", v), 32'(sm[0]), 32'(tbl[v].s));
            chk_eq($sformatf("tbl%0d cout", v), 32'(co[0]), 32'(tbl[v].c));
            chk_eq($sformatf("tbl%0d ovf", v), 32'(ov[0]), 32'(tbl[v].o));
            tick();
        end
        repeat (4) tick();
        check_drained("table");

        // ---- backpressure: 8 beats a=i, b=2i, out_ready 1,0,0,1,... ----
        check_lat = 1'b0;
        n0    = n_out[0];
        i     = 0;
        guard = 0;
        while (i < 8 && guard < 100) begin
            out_ready = bp[guard % 4];
            drive(1'b1, 16'(i), 16'(2 * i), 1'b0, 1'b0);
            #1;
            for (int j = 0; j < 4; j++)
                chk_eq($sformatf("d%0d in_ready vs stall", j), 32'(ir[j]), 32'(!(ovl[j] && !out_ready)));
            tick();
            if (acc[0]) i++;
            guard++;
        end
        chk_eq("backpressure beats sent", 32'(i), 32'd8);
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (8) tick();
        chk_eq("backpressure d0 result count", 32'(n_out[0] - n0), 32'd8);
        check_drained("backpressure");

        // ---- random back-to-back sweep, out_ready=1 ----
        check_lat = 1'b1;
        n0 = n_out[0];
        for (int r = 0; r < 1000; r++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (6) tick();
        chk_eq("sweep d0 result count", 32'(n_out[0] - n0), 32'd1000);
        check_drained("sweep");

        // ---- 12-bit corner cross product ----
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 4; c++) begin
                    drive(1'b1, {4'h0, corner[x]}, {4'h0, corner[y]}, c[0], c[1]);
                    tick();
                end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (6) tick();
        check_drained("corners");

        // ---- flush with 3 beats in flight ----
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(k + 16'h100), 16'h0033, 1'b0, 1'b0);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_eq($sformatf("flush quiet %0d", k), 32'(ovl[0]), 32'd0);
        end
        drive(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        wait_out("post-flush latency", lat_of[0] - 1);
        chk_eq("post-flush sum", 32'(sm[0]), 32'h3334);
        tick();
        repeat (3) tick();
        check_drained("flush");

        // ---- asynchronous reset mid-operation ----
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'(16'h0200 + k), 16'h0011, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk_eq("pre-reset out_valid", 32'(ovl[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) chk_eq($sformatf("d%0d async reset out_valid", j), 32'(ovl[j]), 32'd0);
        chk_eq("async reset sum", 32'(sm[0]), 32'd0);
        for (int j = 0; j < 4; j++) begin
            exp_q[j].delete();
            t_q[j].delete();
            held_v[j] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk_eq($sformatf("d%0d in_ready after release", j), 32'(ir[j]), 32'd1);
            chk_eq($sformatf("d%0d out_valid after release", j), 32'(ovl[j]), 32'd0);
        end
        drive(1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        wait_out("post-reset latency", lat_of[0] - 1);
        chk_eq("post-reset sum", 32'(sm[0]), 32'h F1F0);
        chk_eq("post-reset cout", 32'(co[0]), 32'd0);
        tick();
        repeat (3) tick();
        check_drained("reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
